// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use bubble, branch flush and multi-cycle multiply freeze.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        branch_taken_id,
  input  logic [4:0]  rw_ex,
  input  logic        wreg_ex,
  input  logic        rmem_ex,
  input  logic        mul_ex,
  input  logic [4:0]  rw_mem,
  input  logic        wreg_mem,
  output logic        enable_pc,
  output logic        enable_ifid,
  output logic        enable_idex,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mul_done,
  output logic        busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {StRun, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q;
  logic        lu;
  logic        freeze;

  // Operand forwarding; EX beats MEM, r0 never forwarded, a load in EX has no result yet.
  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (wreg_ex && (rw_ex != 5'd0) && (rw_ex == rs_id) && !rmem_ex) begin
      fwd_a = 2'd1;
    end else if (wreg_mem && (rw_mem != 5'd0) && (rw_mem == rs_id)) begin
      fwd_a = 2'd2;
    end
    if (wreg_ex && (rw_ex != 5'd0) && (rw_ex == rt_id) && !rmem_ex) begin
      fwd_b = 2'd1;
    end else if (wreg_mem && (rw_mem != 5'd0) && (rw_mem == rt_id)) begin
      fwd_b = 2'd2;
    end
  end

  // Hazard detection and multiply sequencer next state.
  always_comb begin
    lu = rmem_ex && wreg_ex && (rw_ex != 5'd0) &&
         ((use_rs_id && (rw_ex == rs_id)) || (use_rt_id && (rw_ex == rt_id)));
    freeze   = 1'b0;
    mul_done = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StRun: begin
        if (mul_ex) begin
          freeze  = 1'b1;
          state_d = StWait;
          cnt_d   = 8'(MUL_CYCLES - 1);
        end
      end
      StWait: begin
        if (cnt_q != 8'd1) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - 8'd1;
        end else begin
          mul_done = 1'b1;
          state_d  = StRun;
          cnt_d    = 8'd0;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Stage-register controls: freeze > load-use > branch flush > normal.
  always_comb begin
    enable_pc   = 1'b1;
    enable_ifid = 1'b1;
    enable_idex = 1'b1;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    busy        = 1'b0;
    if (freeze) begin
      enable_pc   = 1'b0;
      enable_ifid = 1'b0;
      enable_idex = 1'b0;
      busy        = 1'b1;
    end else if (lu) begin
      enable_pc   = 1'b0;
      enable_ifid = 1'b0;
      bubble_idex = 1'b1;
    end else if (branch_taken_id) begin
      flush_ifid = 1'b1;
    end
  end

  // Sequencer state and saturating stall counter.
  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_q     <= StRun;
      cnt_q       <= 8'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((freeze || lu) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; one instance with MUL_CYCLES=4, one with 2.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_0;
  logic [4:0] rs_id, rt_id, rw_ex, rw_mem;
  logic       use_rs_id, use_rt_id, branch_taken_id;
  logic       wreg_ex, rmem_ex, wreg_mem, mul_ex4, mul_ex2;

  logic        en_pc4, en_ifid4, en_idex4, bub4, fl4, done4, busy4;
  logic        en_pc2, en_ifid2, en_idex2, bub2, fl2, done2, busy2;
  logic [1:0]  fwd_a4, fwd_b4, fwd_a2, fwd_b2;
  logic [31:0] stall4, stall2;
  logic [6:0]  ctl4, ctl2;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed control view: {enable_pc, enable_ifid, enable_idex, bubble, flush, busy, mul_done}.
  localparam logic [6:0] Norm  = 7'b111_0000;
  localparam logic [6:0] Lu    = 7'b001_1000;
  localparam logic [6:0] Flush = 7'b111_0100;
  localparam logic [6:0] Frz   = 7'b000_0010;
  localparam logic [6:0] Done  = 7'b111_0001;

  assign ctl4 = {en_pc4, en_ifid4, en_idex4, bub4, fl4, busy4, done4};
  assign ctl2 = {en_pc2, en_ifid2, en_idex2, bub2, fl2, busy2, done2};

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MUL_CYCLES(4)) u_dut4 (
    .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_taken_id(branch_taken_id),
    .rw_ex(rw_ex), .wreg_ex(wreg_ex), .rmem_ex(rmem_ex), .mul_ex(mul_ex4),
    .rw_mem(rw_mem), .wreg_mem(wreg_mem),
    .enable_pc(en_pc4), .enable_ifid(en_ifid4), .enable_idex(en_idex4),
    .bubble_idex(bub4), .flush_ifid(fl4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .mul_done(done4), .busy(busy4), .stall_cnt(stall4)
  );

  pipe_hazard_ctrl #(.MUL_CYCLES(2)) u_dut2 (
    .clock(clock), .reset_0(reset_0), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_taken_id(branch_taken_id),
    .rw_ex(rw_ex), .wreg_ex(wreg_ex), .rmem_ex(rmem_ex), .mul_ex(mul_ex2),
    .rw_mem(rw_mem), .wreg_mem(wreg_mem),
    .enable_pc(en_pc2), .enable_ifid(en_ifid2), .enable_idex(en_idex2),
    .bubble_idex(bub2), .flush_ifid(fl2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .mul_done(done2), .busy(busy2), .stall_cnt(stall2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_id = 5'd0; rt_id = 5'd0; rw_ex = 5'd0; rw_mem = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; branch_taken_id = 1'b0;
    wreg_ex = 1'b0; rmem_ex = 1'b0; wreg_mem = 1'b0; mul_ex4 = 1'b0; mul_ex2 = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked #1 later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lu();
    rmem_ex = 1'b1; wreg_ex = 1'b1; rw_ex = 5'd8; rt_id = 5'd8; use_rt_id = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_0 = 1'b0;
    #12;
    check_eq("reset_ctl", 32'(ctl4), 32'(Norm));
    check_eq("reset_stall", stall4, 32'd0);
    @(negedge clock);
    reset_0 = 1'b1;
    step();

    // Forwarding priority
    rs_id = 5'd5; rw_ex = 5'd5; wreg_ex = 1'b1; rw_mem = 5'd5; wreg_mem = 1'b1; #1;
    check_eq("fwd_ex_prio", 32'(fwd_a4), 32'd1);
    rw_ex = 5'd0; #1;
    check_eq("fwd_mem", 32'(fwd_a4), 32'd2);
    rs_id = 5'd0; rw_mem = 5'd0; #1;
    check_eq("fwd_r0", 32'(fwd_a4), 32'd0);
    rt_id = 5'd7; rw_mem = 5'd7; rw_ex = 5'd7; rmem_ex = 1'b1; #1;
    check_eq("fwd_b_load_skips_ex", 32'(fwd_b4), 32'd2);
    clear_inputs(); #1;
    check_eq("fwd_idle_ctl", 32'(ctl4), 32'(Norm));

    // Load-use: one bubble, then load sits in MEM
    set_lu(); #1;
    check_eq("lu_ctl", 32'(ctl4), 32'(Lu));
    check_eq("lu_stall_pre", stall4, 32'd0);
    step();
    clear_inputs(); rt_id = 5'd8; use_rt_id = 1'b1; rw_mem = 5'd8; wreg_mem = 1'b1; #1;
    check_eq("lu_after_ctl", 32'(ctl4), 32'(Norm));
    check_eq("lu_after_fwd_b", 32'(fwd_b4), 32'd2);
    check_eq("lu_stall_post", stall4, 32'd1);
    clear_inputs(); set_lu(); use_rt_id = 1'b0; #1;
    check_eq("no_use_ctl", 32'(ctl4), 32'(Norm));
    step();
    check_eq("no_use_stall", stall4, 32'd1);

    // Branch concurrent with load-use is held, then flushes
    set_lu(); use_rt_id = 1'b1; branch_taken_id = 1'b1; #1;
    check_eq("br_lu_ctl", 32'(ctl4), 32'(Lu));
    step();
    rmem_ex = 1'b0; wreg_ex = 1'b0; #1;
    check_eq("br_flush_ctl", 32'(ctl4), 32'(Flush));
    check_eq("br_stall", stall4, 32'd2);
    clear_inputs();

    // MUL_CYCLES=4 with load-use and branch during the first frozen cycle
    step();
    mul_ex4 = 1'b1; set_lu(); branch_taken_id = 1'b1; #1;
    check_eq("mul4_c1_frz_prio", 32'(ctl4), 32'(Frz));
    check_eq("mul4_c1_dut2_lu", 32'(ctl2), 32'(Lu));
    step();
    clear_inputs(); mul_ex4 = 1'b1; #1;
    check_eq("mul4_c2", 32'(ctl4), 32'(Frz));
    step();
    check_eq("mul4_c3", 32'(ctl4), 32'(Frz));
    step();
    mul_ex4 = 1'b0; #1;
    check_eq("mul4_done", 32'(ctl4), 32'(Done));
    step();
    check_eq("mul4_after", 32'(ctl4), 32'(Norm));
    check_eq("mul4_stall", stall4, 32'd5);
    check_eq("dut2_stall_pre", stall2, 32'd3);

    // MUL_CYCLES=2, back-to-back multiply
    mul_ex2 = 1'b1; #1;
    check_eq("mul2_c1", 32'(ctl2), 32'(Frz));
    step();
    check_eq("mul2_done1", 32'(ctl2), 32'(Done));
    step();
    check_eq("mul2_b2b_frz", 32'(ctl2), 32'(Frz));
    step();
    mul_ex2 = 1'b0; #1;
    check_eq("mul2_done2", 32'(ctl2), 32'(Done));
    step();
    check_eq("mul2_after", 32'(ctl2), 32'(Norm));
    check_eq("mul2_stall", stall2, 32'd5);
    check_eq("mul2_dut4_idle", stall4, 32'd5);

    // Asynchronous reset in WAIT with cnt = 2
    mul_ex4 = 1'b1;
    step();
    mul_ex4 = 1'b0;
    step();
    #1;
    check_eq("rst_pre_frz", 32'(ctl4), 32'(Frz));
    #2;
    reset_0 = 1'b0;
    #1;
    check_eq("rst_async_ctl", 32'(ctl4), 32'(Norm));
    check_eq("rst_async_stall", stall4, 32'd0);
    @(negedge clock);
    reset_0 = 1'b1;
    step();
    check_eq("rst_no_done1", 32'(ctl4), 32'(Norm));
    step();
    check_eq("rst_no_done2", 32'(ctl4), 32'(Norm));
    check_eq("rst_stall_hold", stall4, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
